// File: rtl/gshare_pattern_history_table_if.sv
// gshare_pattern_history_table_if: lookup, prediction, training and init-status signals of the gshare PHT.
interface gshare_pattern_history_table_if #(
  parameter int INDEX_BITS = 13
);
  logic                  lookup_valid;
  logic [INDEX_BITS-1:0] lookup_index;
  logic                  pred_valid;
  logic                  pred_taken;
  logic [1:0]            pred_counter;
  logic                  update_en;
  logic [INDEX_BITS-1:0] update_index;
  logic                  update_taken;
  logic                  init_busy;
  modport master (
    output lookup_valid, lookup_index, update_en, update_index, update_taken,
    input  pred_valid, pred_taken, pred_counter, init_busy
  );
  modport slave (
    input  lookup_valid, lookup_index, update_en, update_index, update_taken,
    output pred_valid, pred_taken, pred_counter, init_busy
  );
endinterface

// File: rtl/gshare_pattern_history_table.sv
// gshare_pattern_history_table: 2-bit saturating counter array with init sweep, 1-cycle lookup and forwarded 2-stage training.
module gshare_pattern_history_table #(
  parameter int         ENTRY_NUM  = 8192,
  parameter int         INDEX_BITS = $clog2(ENTRY_NUM),
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic clk,
  input logic reset_n,
  gshare_pattern_history_table_if.slave bus
);
  typedef enum logic {INIT, READY} state_t;
  state_t                state, state_nx;
  logic [INDEX_BITS-1:0] init_ptr, init_ptr_nx;
  logic                  init_last;
  logic                  ready;
  logic [1:0]            pht [ENTRY_NUM];
  logic                  u2_valid, u2_taken;
  logic [INDEX_BITS-1:0] u2_index;
  logic [1:0]            u2_old, u2_new, u1_cur, lookup_cur;
  logic                  u1_fire, lookup_fire;
  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    return t ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
  assign ready       = state == READY;
  assign init_last   = init_ptr == INDEX_BITS'(ENTRY_NUM - 1);
  assign u1_fire     = ready && bus.update_en;
  assign lookup_fire = ready && bus.lookup_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nx;
      init_ptr <= init_ptr_nx;
    end
  always_comb begin
    state_nx    = (state == INIT && init_last) ? READY : state;
    init_ptr_nx = (state == INIT) ? init_ptr + 1'b1 : init_ptr;
  end
  // Single write port: the sweep owns it during INIT, the U2 stage afterwards.
  always_ff @(posedge clk)
    if (state == INIT) pht[init_ptr] <= INIT_STATE;
    else if (u2_valid) pht[u2_index] <= u2_new;
  // The U2 result is visible the same cycle it is written, to both the lookup and a chained U1.
  assign u2_new     = sat(u2_old, u2_taken);
  assign u1_cur     = (u2_valid && u2_index == bus.update_index) ? u2_new : pht[bus.update_index];
  assign lookup_cur = (u2_valid && u2_index == bus.lookup_index) ? u2_new : pht[bus.lookup_index];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      u2_valid <= 1'b0;
      u2_taken <= 1'b0;
      u2_index <= '0;
      u2_old   <= '0;
    end else begin
      u2_valid <= u1_fire;
      if (u1_fire) begin
        u2_taken <= bus.update_taken;
        u2_index <= bus.update_index;
        u2_old   <= u1_cur;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.pred_valid   <= 1'b0;
      bus.pred_counter <= 2'b00;
    end else begin
      bus.pred_valid <= lookup_fire;
      if (lookup_fire) bus.pred_counter <= lookup_cur;
    end
  assign bus.pred_taken = bus.pred_counter[1];
  assign bus.init_busy  = state == INIT;
endmodule
